vga_sync_gen: RTL

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_sync_gen.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing generator for a 100 MHz clock with a 25 MHz pixel
// enable. It produces the pixel/line/frame counters, registered active-low sync
// pulses and video_on, and a once-per-frame object-update strobe (move).
// Optional feature macro: VGA_SYNC_MOVE_PRESCALE_EN. When it is defined, move
// fires only on every MOVE_DIV-th frame. When it is undefined, every frame
// qualifies and MOVE_DIV is ignored.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int MOVE_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pause,
  output logic       pixpulse,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       move,
  output logic [7:0] frame
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [1:0] phase_q, phase_d;
  logic       pix_q, pix_d;
  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;
  logic [7:0] frame_q, frame_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_q, video_d;
  // cand_q: the current pixpulse cycle sits at (0, V_ACTIVE). This flag is not
  // yet qualified by the prescaler or by pause.
  logic       cand_q, cand_d;
  logic       qualify_s;

  // Next-state for phase, counters and the timing flags derived from them.
  always_comb begin
    phase_d  = phase_q + 2'd1;
    pix_d    = (phase_d == 2'd3);
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    frame_d  = frame_q;
    if (pix_q) begin
      // Use >= so that an out-of-range value still wraps to zero.
      if (hcount_q >= H_MAX) begin
        hcount_d = 10'd0;
        if (vcount_q >= V_MAX) begin
          vcount_d = 10'd0;
          frame_d  = frame_q + 8'd1;
        end else begin
          vcount_d = vcount_q + 10'd1;
        end
      end else begin
        hcount_d = hcount_q + 10'd1;
      end
    end else begin
      hcount_d = hcount_q;
    end
    hsync_d = ~((hcount_d >= H_SYNC_BEG) && (hcount_d <= H_SYNC_END));
    vsync_d = ~((vcount_d >= V_SYNC_BEG) && (vcount_d <= V_SYNC_END));
    video_d = (hcount_d < H_ACT) && (vcount_d < V_ACT);
    cand_d  = pix_d && (hcount_d == 10'd0) && (vcount_d == V_ACT);
  end

  // Timing state registers, with synchronous reset to the top-left position.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= 2'd0;
      pix_q    <= 1'b0;
      hcount_q <= 10'd0;
      vcount_q <= 10'd0;
      frame_q  <= 8'd0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      video_q  <= 1'b1;
      cand_q   <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      pix_q    <= pix_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      frame_q  <= frame_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      video_q  <= video_d;
      cand_q   <= cand_d;
    end
  end

`ifdef VGA_SYNC_MOVE_PRESCALE_EN
  localparam int PS_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(MOVE_DIV - 1);

  logic [PS_W-1:0] presc_q, presc_d;

  // The prescaler advances once per move candidate, whether or not pause is set.
  always_comb begin
    presc_d = presc_q;
    if (cand_q) begin
      if (presc_q >= PS_MAX) begin
        presc_d = '0;
      end else begin
        presc_d = presc_q + PS_W'(1);
      end
    end else begin
      presc_d = presc_q;
    end
    qualify_s = (presc_q == '0);
  end

  // Prescaler register. After reset it is zero, so the first frame qualifies.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  // Every frame qualifies when the prescaler is not built.
  always_comb begin
    qualify_s = 1'b1;
  end
`endif

  assign pixpulse = pix_q;
  assign hcount   = hcount_q;
  assign vcount   = vcount_q;
  assign frame    = frame_q;
  assign hsync    = hsync_q;
  assign vsync    = vsync_q;
  assign video_on = video_q;
  // pause is sampled in the candidate cycle itself. cand_q is high only while
  // pixpulse is high, so move is never high without pixpulse.
  assign move     = cand_q & qualify_s & ~pause;

endmodule
